// File: rtl/dm_burst_ctrl_if.sv
// Request/response bundle for dm_burst_ctrl: request fields driven by the
// requester, registered load data and completion flags returned by the controller.
interface dm_burst_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              Req;
    logic              We;
    logic [ADDR_W+1:0] A;
    logic [1:0]        Size;
    logic              Sext;
    logic [31:0]       WD;
    logic [31:0]       RD;
    logic              Ready;
    logic              Err;

    modport master (
        output Req, We, A, Size, Sext, WD,
        input  RD, Ready, Err
    );

    modport slave (
        input  Req, We, A, Size, Sext, WD,
        output RD, Ready, Err
    );
endinterface

// File: rtl/dm_burst_ctrl.sv
// Single-access data-memory controller with byte/half/word lanes and a fixed wait count.
// Optional macro DM_MISALIGN_CHECK_EN: flag misaligned accesses instead of aligning them.
module dm_burst_ctrl #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 1
) (
    input  logic          Clk,
    input  logic          Rst_n,
    dm_burst_ctrl_if.slave bus
);
    localparam int         DEPTH  = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_C = 4'(WAIT);

    typedef enum logic [1:0] {IDLE, WAITING, DONE} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              we_reg, sext_reg;
    logic [1:0]        size_reg;
    logic [ADDR_W+1:0] a_reg;
    logic [31:0]       wd_reg, rd_reg;
    logic              accept;

    // In IDLE the live inputs describe the access; afterwards the latched copy does.
    logic              src_we, src_sext;
    logic [1:0]        src_size;
    logic [ADDR_W+1:0] src_a;
    logic [31:0]       src_wd;
    logic [ADDR_W-1:0] src_idx;
    logic [1:0]        src_off;
    logic              src_mis;

    always_comb begin
        if (state_reg == IDLE) begin
            src_we   = bus.We;
            src_sext = bus.Sext;
            src_size = bus.Size;
            src_a    = bus.A;
            src_wd   = bus.WD;
        end else begin
            src_we   = we_reg;
            src_sext = sext_reg;
            src_size = size_reg;
            src_a    = a_reg;
            src_wd   = wd_reg;
        end
    end

    assign src_idx = src_a[ADDR_W+1:2];

    always_comb begin
`ifdef DM_MISALIGN_CHECK_EN
        src_off = src_a[1:0];
        src_mis = ((src_size == 2'b01) && src_a[0]) ||
                  (src_size[1] && (src_a[1:0] != 2'b00));
`else
        src_mis = 1'b0;
        case (src_size)
            2'b00:   src_off = src_a[1:0];
            2'b01:   src_off = {src_a[1], 1'b0};
            default: src_off = 2'b00;
        endcase
`endif
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.Req) begin
                    accept     = 1'b1;
                    cnt_next   = WAIT_C;
                    state_next = (WAIT == 0) ? DONE : WAITING;
                end
            end
            WAITING: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg <= 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            sext_reg  <= 1'b0;
            size_reg  <= 2'b00;
            a_reg     <= '0;
            wd_reg    <= 32'h0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg   <= bus.We;
                sext_reg <= bus.Sext;
                size_reg <= bus.Size;
                a_reg    <= bus.A;
                wd_reg   <= bus.WD;
            end
        end
    end

    // Byte-lane enables and lane-replicated write data
    logic [3:0]  lane_en;
    logic [31:0] wr_lanes;
    logic        wr_en;
    logic [31:0] rd_word;

    always_comb begin
        case (src_size)
            2'b00: begin
                lane_en  = 4'b0001 << src_off;
                wr_lanes = {4{src_wd[7:0]}};
            end
            2'b01: begin
                lane_en  = src_off[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{src_wd[15:0]}};
            end
            default: begin
                lane_en  = 4'b1111;
                wr_lanes = src_wd;
            end
        endcase
    end

    assign wr_en = (state_reg == DONE) && src_we && !src_mis;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge Clk) begin
                if (wr_en && lane_en[gi]) begin
                    lane_mem[src_idx] <= wr_lanes[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[src_idx];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic        load_done;

    always_comb begin
        case (src_off)
            2'b00:   sel_byte = rd_word[7:0];
            2'b01:   sel_byte = rd_word[15:8];
            2'b10:   sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
        sel_half = src_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (src_size)
            2'b00:   load_data = {{24{src_sext & sel_byte[7]}}, sel_byte};
            2'b01:   load_data = {{16{src_sext & sel_half[15]}}, sel_half};
            default: load_data = rd_word;
        endcase
    end

    // RD takes the new value on the edge entering DONE so it is valid alongside Ready.
    assign load_done = (state_next == DONE) && (state_reg != DONE) && !src_we && !src_mis;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_reg <= 32'h0;
        end else if (load_done) begin
            rd_reg <= load_data;
        end
    end

    assign bus.RD    = rd_reg;
    assign bus.Ready = (state_reg == DONE);
    assign bus.Err   = (state_reg == DONE) && src_mis;
endmodule

// File: tb/tb_dm_burst_ctrl.sv
// Scoreboard bench for dm_burst_ctrl: three instances (WAIT=1, 3, 0) with directed
// accesses; each Ready pulse is checked for latency, RD and Err against queued expectations.
module tb_dm_burst_ctrl;
`ifdef DM_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic Clk;
    logic rst_n;
    logic rst3_n;
    int   cyc;
    int   checks;
    int   errors;
    bit   mon_en;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t q0[$];

    dm_burst_ctrl_if #(.ADDR_W(10)) b1();
    dm_burst_ctrl_if #(.ADDR_W(10)) b3();
    dm_burst_ctrl_if #(.ADDR_W(10)) b0();

    dm_burst_ctrl #(.ADDR_W(10), .WAIT(1)) u1 (.Clk(Clk), .Rst_n(rst_n),  .bus(b1));
    dm_burst_ctrl #(.ADDR_W(10), .WAIT(3)) u3 (.Clk(Clk), .Rst_n(rst3_n), .bus(b3));
    dm_burst_ctrl #(.ADDR_W(10), .WAIT(0)) u0 (.Clk(Clk), .Rst_n(rst_n),  .bus(b0));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitors: pop an expectation on every Ready pulse
    always @(negedge Clk) begin
        if (mon_en) begin
            if (b1.Ready === 1'b1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL u1_unexpected_ready: got Ready=1 at cycle %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    $display("u1 txn: cycle %0d RD=%h Err=%b", cyc, b1.RD, b1.Err);
                    chk("u1_latency", 32'(cyc), 32'(e.cyc));
                    chk("u1_rd", b1.RD, e.rd);
                    chk("u1_err", {31'h0, b1.Err}, {31'h0, e.err});
                end
            end else begin
                chk("u1_err_without_ready", {31'h0, b1.Err}, 32'h0);
            end
        end
    end

    always @(negedge Clk) begin
        if (mon_en) begin
            if (b3.Ready === 1'b1) begin
                if (q3.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL u3_unexpected_ready: got Ready=1 at cycle %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = q3.pop_front();
                    $display("u3 txn: cycle %0d RD=%h Err=%b", cyc, b3.RD, b3.Err);
                    chk("u3_latency", 32'(cyc), 32'(e.cyc));
                    chk("u3_rd", b3.RD, e.rd);
                    chk("u3_err", {31'h0, b3.Err}, {31'h0, e.err});
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (mon_en) begin
            if (b0.Ready === 1'b1) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL u0_unexpected_ready: got Ready=1 at cycle %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    $display("u0 txn: cycle %0d RD=%h Err=%b", cyc, b0.RD, b0.Err);
                    chk("u0_latency", 32'(cyc), 32'(e.cyc));
                    chk("u0_rd", b0.RD, e.rd);
                    chk("u0_err", {31'h0, b0.Err}, {31'h0, e.err});
                end
            end
        end
    end

    // One access on the WAIT=1 instance; inputs are scrambled once the request is taken
    task automatic op1(input logic we, input logic [11:0] a, input logic [1:0] sz,
                       input logic sx, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr);
        @(posedge Clk); #1;
        b1.We = we; b1.A = a; b1.Size = sz; b1.Sext = sx; b1.WD = wd; b1.Req = 1'b1;
        q1.push_back('{cyc + 2, erd, eerr});
        @(posedge Clk); #1;
        b1.Req = 1'b0; b1.We = ~we; b1.A = ~a; b1.Sext = ~sx; b1.WD = ~wd;
        repeat (3) @(posedge Clk);
    endtask

    task automatic op3(input logic we, input logic [11:0] a, input logic [31:0] wd,
                       input logic [31:0] erd);
        @(posedge Clk); #1;
        b3.We = we; b3.A = a; b3.Size = 2'b10; b3.Sext = 1'b0; b3.WD = wd; b3.Req = 1'b1;
        q3.push_back('{cyc + 4, erd, 1'b0});
        @(posedge Clk); #1;
        b3.Req = 1'b0;
        repeat (5) @(posedge Clk);
    endtask

    task automatic drive0(input logic req, input logic we, input logic [11:0] a,
                          input logic [1:0] sz, input logic sx, input logic [31:0] wd);
        b0.Req = req; b0.We = we; b0.A = a; b0.Size = sz; b0.Sext = sx; b0.WD = wd;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; mon_en = 1'b0;
        rst_n = 1'b0; rst3_n = 1'b0;
        b1.Req = 1'b0; b1.We = 1'b0; b1.A = '0; b1.Size = 2'b00; b1.Sext = 1'b0; b1.WD = '0;
        b3.Req = 1'b0; b3.We = 1'b0; b3.A = '0; b3.Size = 2'b00; b3.Sext = 1'b0; b3.WD = '0;
        drive0(1'b0, 1'b0, 12'h000, 2'b00, 1'b0, 32'h0);
        repeat (3) @(posedge Clk);
        #1;
        chk("u1_reset_rd", b1.RD, 32'h0);
        chk("u1_reset_ready", {31'h0, b1.Ready}, 32'h0);
        chk("u1_reset_err", {31'h0, b1.Err}, 32'h0);
        @(negedge Clk);
        rst_n = 1'b1; rst3_n = 1'b1;
        mon_en = 1'b1;

        // WAIT=1 directed accesses
        op1(1'b1, 12'h010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0);
        op1(1'b0, 12'h010, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0);
        op1(1'b1, 12'h012, 2'b00, 1'b0, 32'hAABBCC55, 32'hDEADBEEF, 1'b0);
        op1(1'b0, 12'h010, 2'b10, 1'b0, 32'h0,        32'hDE55BEEF, 1'b0);
        op1(1'b0, 12'h013, 2'b00, 1'b1, 32'h0,        32'hFFFFFFDE, 1'b0);
        op1(1'b0, 12'h013, 2'b00, 1'b0, 32'h0,        32'h000000DE, 1'b0);
        op1(1'b0, 12'h012, 2'b01, 1'b1, 32'h0,        32'hFFFFDE55, 1'b0);
        op1(1'b1, 12'h011, 2'b10, 1'b0, 32'h12345678, 32'hFFFFDE55, CHK);
        op1(1'b0, 12'h010, 2'b10, 1'b0, 32'h0,        CHK ? 32'hDE55BEEF : 32'h12345678, 1'b0);
        op1(1'b0, 12'h012, 2'b01, 1'b0, 32'h0,        CHK ? 32'h0000DE55 : 32'h00001234, 1'b0);
        op1(1'b1, 12'hFFC, 2'b10, 1'b0, 32'hCAFEF00D, CHK ? 32'h0000DE55 : 32'h00001234, 1'b0);
        op1(1'b0, 12'hFFC, 2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0);
        op1(1'b0, 12'hFFF, 2'b00, 1'b1, 32'h0,        32'hFFFFFFCA, 1'b0);
        op1(1'b0, 12'h013, 2'b01, 1'b0, 32'h0,        CHK ? 32'hFFFFFFCA : 32'h00001234, CHK);
        op1(1'b0, 12'hFFE, 2'b01, 1'b0, 32'h0,        32'h0000CAFE, 1'b0);

        // WAIT=3: reset aborts an in-flight store
        op3(1'b1, 12'h020, 32'h11112222, 32'h00000000);
        op3(1'b0, 12'h020, 32'h0,        32'h11112222);
        @(posedge Clk); #1;
        b3.We = 1'b1; b3.A = 12'h020; b3.Size = 2'b10; b3.WD = 32'h99999999; b3.Req = 1'b1;
        @(posedge Clk); #1;
        b3.Req = 1'b0;
        @(posedge Clk); #1;
        rst3_n = 1'b0;
        #1;
        chk("u3_rd_during_reset", b3.RD, 32'h0);
        @(posedge Clk); #1;
        chk("u3_ready_during_reset", {31'h0, b3.Ready}, 32'h0);
        @(negedge Clk);
        rst3_n = 1'b1;
        repeat (6) @(posedge Clk);
        #1;
        chk("u3_rd_after_abort", b3.RD, 32'h0);
        op3(1'b0, 12'h020, 32'h0, 32'h11112222);

        // WAIT=0: Req held high, inputs changed during DONE must be ignored
        @(posedge Clk); #1;
        drive0(1'b1, 1'b1, 12'h040, 2'b10, 1'b0, 32'hA1B2C3D4);
        q0.push_back('{cyc + 1, 32'h00000000, 1'b0});
        @(posedge Clk); #1;
        drive0(1'b1, 1'b1, 12'h040, 2'b10, 1'b0, 32'hFFFFFFFF);
        @(posedge Clk); #1;
        drive0(1'b1, 1'b0, 12'h040, 2'b10, 1'b0, 32'h0);
        q0.push_back('{cyc + 1, 32'hA1B2C3D4, 1'b0});
        @(posedge Clk); #1;
        drive0(1'b1, 1'b1, 12'h040, 2'b10, 1'b0, 32'hFFFFFFFF);
        @(posedge Clk); #1;
        drive0(1'b1, 1'b0, 12'h041, 2'b00, 1'b0, 32'h0);
        q0.push_back('{cyc + 1, 32'h000000C3, 1'b0});
        @(posedge Clk); #1;
        drive0(1'b1, 1'b1, 12'h040, 2'b10, 1'b0, 32'hFFFFFFFF);
        @(posedge Clk); #1;
        drive0(1'b1, 1'b0, 12'h040, 2'b10, 1'b0, 32'h0);
        q0.push_back('{cyc + 1, 32'hA1B2C3D4, 1'b0});
        @(posedge Clk); #1;
        drive0(1'b0, 1'b1, 12'h040, 2'b10, 1'b0, 32'hFFFFFFFF);
        repeat (6) @(posedge Clk);
        #1;

        chk("u1_pending", 32'(q1.size()), 32'h0);
        chk("u3_pending", 32'(q3.size()), 32'h0);
        chk("u0_pending", 32'(q0.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_burst_ctrl.md
DM_BURST_CTRL -- requirements
Module: dm_burst_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width; memory depth is 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter WAIT, default 1, range 0..15, meaning wait cycles inserted before completion.
REQ-003 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port Req  input  1  access request, sampled only in IDLE.
REQ-006 SHALL have port We  input  1  1 = store, 0 = load; sampled with Req.
REQ-007 SHALL have port A  input  ADDR_W+2  byte address; sampled with Req.
REQ-008 SHALL have port Size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-009 SHALL have port Sext  input  1  1 = sign-extend a byte or half load, 0 = zero-extend.
REQ-010 SHALL have port WD  input  32  store data; the low byte, half or full word is used according to Size.
REQ-011 SHALL have port RD  output  32  registered load data.
REQ-012 SHALL have port Ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port Err  output  1  misalignment flag, valid only while Ready=1.

Function
REQ-014 SHALL implement FSM IDLE -> WAITING -> DONE -> IDLE.
- IDLE with Req=1: latch We, A, Size, Sext and WD; load counter with WAIT; go to WAITING, or to DONE directly if WAIT=0.
REQ-015 WAITING SHALL decrement the counter each cycle and go to DONE in the cycle after the counter reads 1; latency from the Req cycle to Ready SHALL be WAIT+1 cycles.
REQ-016 DONE SHALL last exactly one cycle, assert Ready=1, then return to IDLE.
- Req in DONE SHALL be ignored; at most one access every WAIT+2 cycles.
REQ-017 Req, We, A, Size, Sext and WD changes outside IDLE SHALL have no effect.
REQ-018 Store completion SHALL write only the lanes selected by Size and A[1:0] in the cycle Ready=1.
- byte: lane A[1:0]; half: lanes {A[1],0} and {A[1],1}; word: all four lanes.
- Unselected bytes SHALL be preserved.
REQ-019 Load completion SHALL update RD in the cycle Ready=1 with the addressed byte or half, right-justified and extended per Sext, or with the full word.
- RD SHALL hold its value until the next successful load completes; stores SHALL leave RD unchanged.
REQ-020 Word index SHALL be A[ADDR_W+1:2]; addresses SHALL never wrap or alias beyond the depth.
REQ-021 Misaligned access (half with A[0]=1, or word with A[1:0]!=00) SHALL assert Err=1 with Ready, perform no write and leave RD unchanged.
REQ-022 Ready and Err SHALL be 0 in all cycles other than DONE.

Reset
REQ-023 Rst_n=0 SHALL immediately force state IDLE, counter 0, Ready=0, Err=0 and RD=32'h0.
REQ-024 Reset during WAITING or DONE SHALL abort the access with no memory write and no Ready pulse.
REQ-025 Memory array contents SHALL NOT be affected by reset.

Configuration
REQ-026 Macro DM_MISALIGN_CHECK_EN defined: misalignment detection per REQ-021.
REQ-027 Macro DM_MISALIGN_CHECK_EN undefined:
- Err SHALL be tied 0.
- Half accesses SHALL force A[0]=0 and word accesses SHALL force A[1:0]=00, then proceed normally.

Verification
REQ-028 WAIT=1, store word 32'hDEADBEEF to A=0x010, then load word from 0x010 -> each Ready exactly 2 cycles after Req; RD=32'hDEADBEEF.
REQ-029 After REQ-028, store byte 8'h55 to A=0x012, then load word from 0x010 -> RD=32'hDE55BEEF.
REQ-030 Load byte from A=0x013 with Sext=1 -> RD=32'hFFFFFFDE; with Sext=0 -> RD=32'h000000DE; load half from 0x012 with Sext=1 -> RD=32'hFFFFDE55.
REQ-031 With DM_MISALIGN_CHECK_EN, store word to A=0x011 -> Ready=1 with Err=1, word 0x010 unchanged, RD unchanged; without the macro -> write goes to 0x010 and Err=0.
REQ-032 WAIT=3, pulse Rst_n low 2 cycles after a store Req -> no Ready pulse, target word unchanged, RD=0, next Req accepted normally.
REQ-033 WAIT=0, hold Req=1 continuously -> Ready pulses every 2nd cycle; inputs changed while not in IDLE are ignored.
